caravel_ram_banked_wb: RTL
==========================

Name: caravel_ram_banked_wb

Overview:
- Parametrised Wishbone-slave-to-SRAM bridge fronting NB identical 32-bit RAM macros (banks) that share address and write-data buses.
- Decodes the bank from the address and drives a per-bank enable and byte-write-enable.
- Handles a configurable macro read latency and returns registered read data with a single-cycle ack.
- Sits on the Caravel management/user Wishbone bus as the next-generation RAM front end.

Parameters:
AW, 13, word-address bits per bank (bank depth = 2^AW words)
NB, 2, number of banks; power of two, 1..8
RD_LAT, 1, cycles from EN assertion to valid Do at the macro; 1..4

Ports:
wb_clk_i  input  1  clock
wb_rst_i  input  1  reset, synchronous, active-high
wb_adr_i  input  32  byte address; word = [AW+1:2], bank = [AW+2 +: log2(NB)], higher bits ignored
wb_dat_i  input  32  write data
wb_sel_i  input  4  byte lane select
wb_we_i  input  1  1 = write
wb_cyc_i  input  1  bus cycle
wb_stb_i  input  1  strobe
wb_ack_o  output  1  registered ack, one-cycle pulse
wb_dat_o  output  32  registered read data
WE  output  4*NB  byte write enables; bank b uses [4b+3:4b]
EN  output  NB  per-bank enable
Di  output  32  shared write data (= wb_dat_i)
Do  input  32*NB  read data; bank b uses [32b+31:32b]
A  output  AW  shared word address (= wb_adr_i[AW+1:2])

Behaviour:
- Reset, synchronous, active-high:
  - state = IDLE; wb_ack_o = 0; wb_dat_o = 0; wait counter = 0; latched bank = 0.
  - EN and WE are 0 while wb_rst_i is high.
- valid = wb_cyc_i & wb_stb_i. When NB = 1, the bank index is constant 0.
- A and Di are combinational pass-throughs in every state.
- FSM states: IDLE, RWAIT, ACK.
- IDLE, valid and write:
  - EN[bank] = 1 and WE[bank] = wb_sel_i, for this cycle only; all other banks get EN = 0 and WE = 0.
  - Next state ACK. Write ack is high in cycle 1, where cycle 0 is the first valid cycle.
  - wb_sel_i = 0 still completes with an ack; WE stays 0.
- IDLE, valid and read:
  - EN[bank] = 1 and WE = 0.
  - Latch bank, load counter = RD_LAT, next state RWAIT.
- RWAIT:
  - EN[latched bank] = 1, WE = 0. The counter decrements each cycle.
  - In the cycle the counter equals 1, capture wb_dat_o <= Do slice of the latched bank; next state ACK.
  - Read ack is high in cycle RD_LAT+1 with the data valid in the same cycle. RD_LAT = 1 gives ack in cycle 2.
- ACK:
  - wb_ack_o = 1 for exactly one cycle; EN = 0, WE = 0; next state IDLE.
  - valid in this cycle is ignored; a new request is accepted no earlier than the following cycle.
  - Back-to-back throughput: a write completes every 2 cycles; a read every RD_LAT+2 cycles.
- Abort: wb_cyc_i low during RWAIT means state goes to IDLE, no ack is issued, and wb_dat_o is unchanged.
  - A write cannot abort, because it is committed in its first cycle.
- wb_dat_o holds its last captured value between reads; it is not cleared by writes.
- Reset asserted mid-read or mid-ack: the next cycle is IDLE with ack 0 and no spurious ack or WE afterwards.
- Master changing wb_adr_i during RWAIT is a protocol violation. A follows the bus; the result is undefined but the FSM must still terminate in ACK.

Test Plan:
- NB=2, RD_LAT=1: write 0xDEADBEEF, sel=0xF to byte addr 0x0000_0010 -> cycle 0 EN=2'b01, WE[3:0]=0xF, A=4; ack cycle 1 only. Read the same address -> ack cycle 2 with wb_dat_o=0xDEADBEEF.
- Bank decode, AW=13: write 0x12345678 to 0x0000_8004 -> EN=2'b10, WE[7:4]=0xF, A=1, WE[3:0]=0. Read 0x0000_0004 and 0x0000_8004 -> distinct data from each bank.
- Byte lanes: preload 0xFFFFFFFF, write 0x000000AA with sel=0x1 -> readback 0xFFFFFFAA. sel=0x0 write -> ack still arrives, memory unchanged.
- RD_LAT=3: read request at cycle 0 -> EN high cycles 0..3, ack only in cycle 4, data captured from Do at cycle 3. Back-to-back reads -> ack spacing 5 cycles.
- Abort and reset: drop wb_cyc_i in cycle 1 of an RD_LAT=3 read -> no ack, IDLE next, wb_dat_o unchanged. Assert wb_rst_i in RWAIT -> ack=0, wb_dat_o=0, EN=0 next cycle; the next transaction completes normally.
- Stalled master: hold stb high through the ACK cycle -> exactly one ack per request, no duplicate write (WE pulses once).

Source files
------------

// File: rtl/caravel_ram_banked_wb.sv
// Wishbone slave front end for NB banks of 32-bit single-port RAM macros sharing A/Di.
// Reads wait RD_LAT cycles for the macro, then return registered data with a one-cycle ack.
module caravel_ram_banked_wb #(
  parameter int unsigned AW     = 13,
  parameter int unsigned NB     = 2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic [31:0]       wb_dat_o,
  output logic [4*NB-1:0]   WE,
  output logic [NB-1:0]     EN,
  output logic [31:0]       Di,
  input  logic [32*NB-1:0]  Do,
  output logic [AW-1:0]     A
);

  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {StIdle, StRwait, StAck} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [BW-1:0] bank_q, bank_d, bank;
  logic [31:0]   dat_q, dat_d, rd_data;
  logic          ack_q;
  logic          valid;

  logic          en_on;
  logic [BW-1:0] en_bank;
  logic [3:0]    we_mask;

  logic          unused_adr;

  assign valid      = wb_cyc_i & wb_stb_i;
  assign A          = wb_adr_i[AW+1:2];
  assign Di         = wb_dat_i;
  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

  if (NB > 1) begin : g_bank_dec
    assign bank = wb_adr_i[AW+2 +: BW];
  end else begin : g_bank_one
    assign bank = '0;
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (bank_q == BW'(b)) rd_data = Do[32*b +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    dat_d   = dat_q;
    en_on   = 1'b0;
    en_bank = bank;
    we_mask = 4'h0;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          en_on = 1'b1;
          if (wb_we_i) begin
            // Write commits to the macro this cycle; only the ack remains.
            we_mask = wb_sel_i;
            state_d = StAck;
          end else begin
            bank_d  = bank;
            cnt_d   = 3'(RD_LAT);
            state_d = StRwait;
          end
        end
      end
      StRwait: begin
        en_on   = 1'b1;
        en_bank = bank_q;
        cnt_d   = cnt_q - 3'd1;
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (cnt_q == 3'd1) begin
          dat_d   = rd_data;
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (wb_rst_i) begin
      en_on   = 1'b0;
      we_mask = 4'h0;
    end
  end

  always_comb begin
    EN = '0;
    WE = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (en_on && (en_bank == BW'(b))) begin
        EN[b]        = 1'b1;
        WE[4*b +: 4] = we_mask;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bank_q  <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      dat_q   <= dat_d;
      ack_q   <= (state_d == StAck);
    end
  end

endmodule
